// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-indexed memory port of the load/store unit.
// The slave modport is the unit itself; master is the datapath/memory side.
interface mem_access_unit_if #(
   parameter int WIDTH = 32
) ();

   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [1:0]       req_size;
   logic             req_signed;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;

   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;

   logic [WIDTH-1:0] mem_a;
   logic             mem_we;
   logic [WIDTH-1:0] mem_wd;
   logic [WIDTH-1:0] mem_rd;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
   );

endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word accesses to a word-indexed memory, read-modify-write for sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned requests skip memory and respond with rsp_err=1.
module mem_access_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]       size_q, size_d;
   logic             we_q, we_d;
   logic             signed_q, signed_d;
   logic             err_q, err_d;

   logic             accept;
   logic             req_misaligned;
   logic [4:0]       lane_shift;
   logic [WIDTH-1:0] lane_mask;
   logic [WIDTH-1:0] lane_data;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] merged;

   assign accept = (state_q == IDLE) && bus.req_valid;

`ifdef MISALIGN_TRAP_EN
   assign req_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                           (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
   assign req_misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Word stores need no read; sub-word stores read first so untouched lanes survive the write.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_misaligned) begin
                  state_d = RESP;
               end else if (bus.req_we && bus.req_size[1]) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD:      state_d = we_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Size is latched as 00/01/10 so size 11 behaves as a word everywhere downstream.
   always_comb begin
      lane_shift = 5'd0;
      lane_mask  = '1;
      case (size_q)
         2'b00: begin
            lane_shift = {addr_q[1:0], 3'b000};
            lane_mask  = {{(WIDTH-8){1'b0}}, 8'hFF} << lane_shift;
         end
         2'b01: begin
            lane_shift = {addr_q[1], 4'b0000};
            lane_mask  = {{(WIDTH-16){1'b0}}, 16'hFFFF} << lane_shift;
         end
         default: ;
      endcase
      lane_data = (bus.mem_rd & lane_mask) >> lane_shift;
      merged    = (data_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
      case (size_q)
         2'b00:   load_value = signed_q ? {{(WIDTH-8){lane_data[7]}}, lane_data[7:0]}
                                        : {{(WIDTH-8){1'b0}}, lane_data[7:0]};
         2'b01:   load_value = signed_q ? {{(WIDTH-16){lane_data[15]}}, lane_data[15:0]}
                                        : {{(WIDTH-16){1'b0}}, lane_data[15:0]};
         default: load_value = lane_data;
      endcase
   end

   always_comb begin
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      data_d   = data_q;
      rdata_d  = rdata_q;
      size_d   = size_q;
      we_d     = we_q;
      signed_d = signed_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d   = bus.req_addr;
               wdata_d  = bus.req_wdata;
               we_d     = bus.req_we;
               signed_d = bus.req_signed;
               size_d   = bus.req_size[1] ? 2'b10 : bus.req_size;
               err_d    = req_misaligned;
               if (req_misaligned) begin
                  rdata_d = '0;
               end
            end
         end
         RD: begin
            data_d = bus.mem_rd;
            if (!we_q) begin
               rdata_d = load_value;
            end
         end
         WR:      rdata_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         data_q   <= '0;
         rdata_q  <= '0;
         size_q   <= 2'b00;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         data_q   <= data_d;
         rdata_q  <= rdata_d;
         size_q   <= size_d;
         we_q     <= we_d;
         signed_q <= signed_d;
         err_q    <= err_d;
      end
   end

   // Memory controls decode straight from state so an async reset drops mem_we immediately.
   always_comb begin
      bus.req_ready = (state_q == IDLE);
      bus.rsp_valid = (state_q == RESP);
      bus.rsp_err   = (state_q == RESP) && err_q;
      bus.mem_a     = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wd    = '0;
      if ((state_q == RD) || (state_q == WR)) begin
         bus.mem_a = {2'b00, addr_q[WIDTH-1:2]};
      end
      if (state_q == WR) begin
         bus.mem_we = 1'b1;
         bus.mem_wd = merged;
      end
   end

   assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level memory model predicts responses and writes.
// Honours MISALIGN_TRAP_EN the same way as the design build.
module tb_mem_access_unit;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } rsp_t;

   typedef struct packed {
      int          idx;
      logic [31:0] word;
   } wr_t;

   logic clk;
   logic rst;
   int   cycle;
   int   n_checks;
   int   n_fail;

   logic [31:0] ram [0:15];
   logic [7:0]  mb  [0:63];

   rsp_t rsp_q [$];
   wr_t  wr_q  [$];
   rsp_t mon_rsp;
   wr_t  mon_wr;

   mem_access_unit_if #(.WIDTH(32)) bus ();

   mem_access_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Environment memory: combinational read, write on the clock edge.
   assign bus.mem_rd = ram[bus.mem_a[3:0]];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_a[3:0]] <= bus.mem_wd;
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic report_fail(input string name);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: event occurred, none expected", name);
   endtask

   function automatic logic [31:0] model_word(input int idx);
      logic [31:0] w;
      w = 32'h0;
      for (int i = 0; i < 4; i++) w = w | (32'(mb[idx*4+i]) << (8*i));
      return w;
   endfunction

   // Response and write monitor, fully decoupled from the stimulus process.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
               report_fail("unexpected_rsp");
            end else begin
               mon_rsp = rsp_q.pop_front();
               check_output("rsp_rdata", bus.rsp_rdata, mon_rsp.rdata);
               check_output("rsp_err", 32'(bus.rsp_err), 32'(mon_rsp.err));
               check_output("rsp_latency", cycle, mon_rsp.due);
               check_output("ready_in_resp", 32'(bus.req_ready), 32'd0);
            end
         end
         if (bus.mem_we) begin
            if (wr_q.size() == 0) begin
               report_fail("unexpected_write");
            end else begin
               mon_wr = wr_q.pop_front();
               check_output("mem_a", bus.mem_a, mon_wr.idx);
               check_output("mem_wd", bus.mem_wd, mon_wr.word);
            end
         end
         if (bus.req_ready) begin
            check_output("idle_mem_a", bus.mem_a, 32'd0);
         end
      end
   end

   task automatic randomize_idle_inputs();
      bus.req_we     = 1'($urandom_range(0, 1));
      bus.req_size   = 2'($urandom_range(0, 3));
      bus.req_signed = 1'($urandom_range(0, 1));
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
   endtask

   // Caller is at a negedge; returns at the negedge following the accept edge.
   task automatic apply_stimulus(input bit we, input bit [1:0] size, input bit sgn,
                                 input int addr, input logic [31:0] wdata);
      int          n;
      int          base;
      int          lat;
      int          waited;
      bit          trap;
      logic [63:0] val;
      rsp_t        r;
      wr_t         w;
      n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      base = addr - (addr % n);
      trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap = (addr % n) != 0;
`endif
      r.rdata = 32'h0;
      r.err   = 1'b0;
      w.idx   = 0;
      w.word  = 32'h0;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      waited = 0;
      while (!bus.req_ready && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.req_ready) begin
         report_fail("accept_timeout");
         bus.req_valid = 1'b0;
         return;
      end
      if (trap) begin
         r.err = 1'b1;
         lat   = 1;
      end else if (!we) begin
         val = 64'h0;
         for (int i = 0; i < n; i++) val = val | (64'(mb[base+i]) << (8*i));
         if (sgn && n < 4 && val[8*n-1]) val = val - (64'd1 << (8*n));
         r.rdata = val[31:0];
         lat     = 2;
      end else begin
         for (int i = 0; i < n; i++) mb[base+i] = 8'(wdata >> (8*i));
         w.idx  = base / 4;
         w.word = model_word(base / 4);
         wr_q.push_back(w);
         lat = (n == 4) ? 2 : 3;
      end
      r.due = cycle + lat;
      rsp_q.push_back(r);
      @(negedge clk);
      bus.req_valid = 1'b0;
      randomize_idle_inputs();
   endtask

   task automatic wait_drain();
      int waited;
      waited = 0;
      while ((rsp_q.size() != 0 || wr_q.size() != 0 || !bus.req_ready) && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_output("queues_drained", rsp_q.size() + wr_q.size(), 32'd0);
   endtask

   initial begin
      wr_t abort_wr;
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      wr_t abort_wr;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      bus.req_valid = 1'b0;
      randomize_idle_inputs();
      repeat (3) @(negedge clk);
      check_output("reset_ready", 32'(bus.req_ready), 32'd1);
      check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_output("reset_rdata", bus.rsp_rdata, 32'd0);
      check_output("reset_err", 32'(bus.rsp_err), 32'd0);
      check_output("reset_mem_we", 32'(bus.mem_we), 32'd0);
      check_output("reset_mem_a", bus.mem_a, 32'd0);
      check_output("reset_mem_wd", bus.mem_wd, 32'd0);
      rst = 1'b1;

      $display("[TB] initialising memory through word stores");
      for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 2'b10, 1'b0, i * 4, $urandom);

      $display("[TB] word store then word load at 0x8");
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
      apply_stimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      wait_drain();

      $display("[TB] reset during write");
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_size   = 2'b10;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h12345678;
      abort_wr.idx   = 4;
      abort_wr.word  = 32'h12345678;
      wr_q.push_back(abort_wr);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_output("abort_we_high", 32'(bus.mem_we), 32'd1);
      #2 rst = 1'b0;
      #1;
      check_output("abort_we_low", 32'(bus.mem_we), 32'd0);
      check_output("abort_ready", 32'(bus.req_ready), 32'd1);
      check_output("abort_rdata", bus.rsp_rdata, 32'd0);
      check_output("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      check_output("abort_mem_kept", ram[4], model_word(4));

      $display("[TB] byte store read-modify-write");
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
      apply_stimulus(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFFAA);

      $display("[TB] sub-word loads with extension");
      apply_stimulus(1'b1, 2'b10, 1'b0, 32'h0, 32'h80F17F01);
      apply_stimulus(1'b0, 2'b00, 1'b1, 32'h2, 32'h0);
      apply_stimulus(1'b0, 2'b00, 1'b0, 32'h2, 32'h0);
      apply_stimulus(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
      apply_stimulus(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);

      $display("[TB] misaligned half load at 0x3");
      apply_stimulus(1'b0, 2'b01, 1'b1, 32'h3, 32'h0);
      wait_drain();

      $display("[TB] back-to-back loads with valid held");
      apply_stimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      apply_stimulus(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
      wait_drain();

      $display("[TB] randomized traffic");
      for (int t = 0; t < 300; t++) begin
         apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 63), $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain();

      for (int i = 0; i < 16; i++) check_output("final_mem_word", ram[i], model_word(i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit between the MIPS datapath and the word-organised data memory. It accepts byte, halfword and word requests on a valid/ready handshake and drives the memory's word-indexed port: A = word index, combinational RD, WE/WD written on posedge clk. Sub-word stores use a read-modify-write sequence. Loads return extracted lanes, sign- or zero-extended.

Parameters:
WIDTH, 32, data and address width; lane logic is defined for 32 only.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept; equals (state==IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  input  WIDTH  byte address
req_wdata  input  WIDTH  store data, right-aligned
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  WIDTH  load result, registered
rsp_err  output  1  misalignment flag; valid with rsp_valid
mem_a  output  WIDTH  word index to memory = {2'b00, addr[WIDTH-1:2]}
mem_we  output  1  memory write enable
mem_wd  output  WIDTH  memory write data
mem_rd  input  WIDTH  memory read data, combinational from mem_a

Behaviour:
- Reset (rst low, async): state IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_a=0, mem_wd=0. req_ready=1. Internal latches cleared. Reset mid-sequence aborts the sequence at once: mem_we drops immediately and no partial write completes after reset.
- Accept: on a posedge with req_valid=1 and state=IDLE, latch addr, size, we, signed and wdata. Inputs are ignored in every other state.
- States: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - load -> RD
  - store word -> WR
  - store byte/half -> RD
- Transitions from RD: load -> RESP; store -> WR. In RD, mem_a is driven and mem_rd is captured into the internal data register at the edge.
- In WR: mem_we=1 and mem_wd = merged word. Always -> RESP.
- In RESP: rsp_valid=1 for exactly one cycle. Always -> IDLE.
- mem_a holds the latched word index in RD and WR, and is 0 in IDLE and RESP. mem_we=1 only in WR.
- Latency from accept edge to the rsp_valid cycle:
  - load: 2 edges
  - word store: 2 edges
  - sub-word store: 3 edges
- Throughput: the next accept is no earlier than the IDLE cycle following RESP.
- Lane mapping is little-endian. Byte k occupies bits [8k+7:8k], with k = addr[1:0]. A halfword uses lanes {2·addr[1]+1, 2·addr[1]}.
- Load extract: the selected lane(s) are right-aligned, then extended with the lane MSB if signed=1, otherwise with 0. A word load ignores req_signed.
- Store merge: the selected lane(s) are replaced by the low 8/16 bits of wdata. All other lanes keep the captured mem_rd value.
- rsp_rdata:
  - updated at the RD->RESP edge for loads only
  - set to 0 at the entry to RESP for stores
  - held otherwise until the next response
- Misaligned addresses (feature absent): a half ignores addr[0]; a word ignores addr[1:0].

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined: a request is misaligned if it is a half with addr[0]=1, or a word with addr[1:0]≠0. A misaligned request is accepted, goes IDLE->RESP directly, performs no memory access (mem_we stays 0), and responds with rsp_err=1 and rsp_rdata=0.
- Undefined: rsp_err is tied 0 and misaligned addresses are forced aligned as above.

Test Plan:
1. Reset with rst=0 mid-WR (mem_we=1) -> mem_we=0 immediately, state IDLE, req_ready=1, rsp_rdata=0; memory word unchanged.
2. Word store 0xDEADBEEF to addr 0x8, then word load from 0x8 -> mem_we for one cycle with mem_a=2, mem_wd=0xDEADBEEF; load rsp_rdata=0xDEADBEEF, 2 edges after accept.
3. Memory word 1 = 0x11223344; byte store 0xAA to addr 0x5 -> sequence RD, WR with mem_wd=0x1122AA44, rsp_valid 3 edges after accept.
4. Memory word 0 = 0x80F17F01; lb at 0x2 -> 0xFFFFFFF1; lbu at 0x2 -> 0x000000F1; lh at 0x2 -> 0xFFFF80F1; lhu at 0x0 -> 0x00007F01.
5. Back-to-back req_valid held high across two loads -> second accept only in IDLE after the first RESP; req_ready=0 in RD and RESP; exactly two rsp_valid pulses.
6. Half load at 0x3:
   - with MISALIGN_TRAP_EN: rsp_err=1, rsp_rdata=0, one edge after accept, no mem access.
   - without: treated as 0x2, rsp_err=0.
